// File: rtl/m_unit_arbiter.sv
// m_unit_arbiter: round-robin arbiter sharing one PCPI M-extension unit among NUM_REQ requesters.
// Define M_ARB_TIMEOUT_EN to add the BUSY watchdog (TIMEOUT_CYCLES) with DRAIN recovery.
module m_unit_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*32-1:0] req_insn,
   input  logic [NUM_REQ*32-1:0] req_rs1,
   input  logic [NUM_REQ*32-1:0] req_rs2,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [NUM_REQ-1:0]    req_wr,
   output logic [NUM_REQ-1:0]    req_busy,
   output logic [31:0]           req_rd,
   output logic                  m_valid,
   output logic [31:0]           m_insn,
   output logic [31:0]           m_rs1,
   output logic [31:0]           m_rs2,
   input  logic                  m_ready,
   input  logic                  m_wr,
   input  logic [31:0]           m_rd,
   input  logic                  m_busy,
   output logic                  timeout_err
);
   localparam int IW = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;
   state_t state;
   logic [IW-1:0] ptr, gnt, off, pick;
   logic [IW:0] sum;
   logic [NUM_REQ-1:0] elig, rot, gnt_oh;
   logic [2*NUM_REQ-1:0] dbl;
   logic [31:0] insn_a [NUM_REQ];
   logic [31:0] rs1_a [NUM_REQ];
   logic [31:0] rs2_a [NUM_REQ];
   logic [31:0] rd;
   logic wr;
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 128) begin : g_bad_cfg
      $error("m_unit_arbiter: unsupported parameter values");
   end
   genvar i;
   for (i = 0; i < NUM_REQ; i++) begin : g_req
      assign insn_a[i] = req_insn[32*i +: 32];
      assign rs1_a[i]  = req_rs1[32*i +: 32];
      assign rs2_a[i]  = req_rs2[32*i +: 32];
      assign elig[i]   = req_valid[i] && insn_a[i][6:0] == 7'b0110011 && insn_a[i][31:25] == 7'b0000001;
   end
   // Rotate eligibility so bit 0 is ptr; the lowest set bit is then the round-robin winner.
   assign dbl = {elig, elig} >> ptr;
   assign rot = dbl[NUM_REQ-1:0];
   always_comb begin
      off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (rot[k]) off = IW'(k);
   end
   assign sum  = {1'b0, ptr} + {1'b0, off};
   assign pick = IW'(sum >= (IW+1)'(NUM_REQ) ? sum - (IW+1)'(NUM_REQ) : sum);
   assign gnt_oh    = NUM_REQ'(1) << gnt;
   assign m_insn    = insn_a[gnt];
   assign m_rs1     = rs1_a[gnt];
   assign m_rs2     = rs2_a[gnt];
   assign req_ready = (state == RESP) ? gnt_oh : '0;
   assign req_wr    = (state == RESP && wr) ? gnt_oh : '0;
   assign req_busy  = (state == BUSY || state == DRAIN) ? gnt_oh : '0;
   assign req_rd    = (state == RESP) ? rd : '0;
`ifdef M_ARB_TIMEOUT_EN
   logic [6:0] cnt;
   logic to_flag;
   assign timeout_err = (state == RESP) && to_flag;
`else
   assign timeout_err = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt     <= '0;
         m_valid <= 1'b0;
         rd      <= '0;
         wr      <= 1'b0;
`ifdef M_ARB_TIMEOUT_EN
         cnt     <= '0;
         to_flag <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (|rot) begin
               gnt     <= pick;
               m_valid <= 1'b1;
               state   <= BUSY;
`ifdef M_ARB_TIMEOUT_EN
               cnt     <= '0;
               to_flag <= 1'b0;
`endif
            end
            BUSY: begin
               if (m_ready) begin
                  rd      <= m_rd;
                  wr      <= m_wr;
                  m_valid <= 1'b0;
                  state   <= RESP;
               end
`ifdef M_ARB_TIMEOUT_EN
               else if (cnt == 7'(TIMEOUT_CYCLES - 1)) begin
                  rd      <= '0;
                  wr      <= 1'b0;
                  to_flag <= 1'b1;
                  m_valid <= 1'b0;
                  state   <= RESP;
               end else cnt <= cnt + 7'd1;
`endif
            end
            RESP: begin
               ptr   <= (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
`ifdef M_ARB_TIMEOUT_EN
               state <= DRAIN;
`else
               state <= IDLE;
`endif
            end
            default: if (!m_busy && !m_ready) state <= IDLE;
         endcase
      end
   end
endmodule
